if_fetch_stage: RTL and testbench

Instruction-fetch stage directly upstream of the IF/ID pipeline register. It owns the fetch PC and issues in-order requests to instruction memory over a req/gnt/rvalid handshake. Responses are held in a small prefetch buffer. Each cycle it presents one {PC_if, inst_if} pair, or a bubble (inst_if = 0), to the IF/ID register, and it handles stall hold and branch redirect with wrong-path discard.

---
 rtl/if_fetch_stage.sv | 126 ++++++++++++
 tb/tb_if_fetch_stage.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - instruction fetch stage with in-order prefetch buffer and redirect discard
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_if,
  output logic [31:0] inst_if
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   pc_q   [DEPTH];
  logic [31:0]   pc_d   [DEPTH];
  logic [31:0]   inst_q [DEPTH];
  logic [31:0]   inst_d [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] nfill_q, nfill_d;
  logic [CW-1:0] drop_q, drop_d;

  logic [CW-1:0] unfilled, pending;
  logic [PW-1:0] fill_idx;
  logic          head_filled, alloc, pop, fill, room;
  logic          unused_bits;

  // Filled entries are always contiguous from head, so a fill count replaces per-entry flags.
  assign unfilled    = count_q - nfill_q;
  assign pending     = drop_q + unfilled;
  assign fill_idx    = head_q + nfill_q[PW-1:0];
  assign head_filled = (nfill_q != '0);
  assign room        = ({1'b0, count_q} + {1'b0, drop_q}) < (CW+1)'(DEPTH);
  assign unused_bits = ^{stall[5:2], stall[0], branch_target[1:0]};

  assign imem_req  = rst & ~branch_flag & room;
  assign imem_addr = fetch_pc_q;
  assign alloc     = imem_req & imem_gnt;
  assign pop       = head_filled & ~stall[1] & ~branch_flag;
  assign fill      = imem_rvalid & (drop_q == '0) & (unfilled != '0);

  always_comb begin
    PC_if   = fetch_pc_q;
    inst_if = 32'h0;
    if (!rst) begin
      PC_if = RESET_PC;
    end else if (head_filled) begin
      PC_if   = pc_q[head_q];
      inst_if = branch_flag ? 32'h0 : inst_q[head_q];
    end else if (count_q != '0) begin
      PC_if = pc_q[head_q];
    end
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    nfill_d    = nfill_q;
    drop_d     = drop_q;
    if (branch_flag) begin
      // Every still-unfilled entry becomes a response to throw away.
      fetch_pc_d = {branch_target[31:2], 2'b00};
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      nfill_d    = '0;
      drop_d     = (imem_rvalid && pending != '0) ? pending - CW'(1) : pending;
    end else begin
      if (alloc) begin
        pc_d[tail_q] = fetch_pc_q;
        tail_d       = tail_q + PW'(1);
        fetch_pc_d   = fetch_pc_q + 32'd4;
      end
      if (imem_rvalid && drop_q != '0) begin
        drop_d = drop_q - CW'(1);
      end
      if (fill) begin
        inst_d[fill_idx] = imem_rdata;
      end
      if (pop) begin
        head_d = head_q + PW'(1);
      end
      count_d = count_q + CW'(alloc) - CW'(pop);
      nfill_d = nfill_q + CW'(fill) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      nfill_q    <= '0;
      drop_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= 32'h0;
        inst_q[i] <= 32'h0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      nfill_q    <= nfill_d;
      drop_q     <= drop_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - directed bench for if_fetch_stage with an in-order latency memory
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] PC_if;
  logic [31:0] inst_if;

  logic [5:0]  stall2;
  logic        branch2;
  logic [31:0] target2;
  logic        req2;
  logic [31:0] addr2;
  logic        gnt2;
  logic        rvalid2;
  logic [31:0] rdata2;
  logic [31:0] pc2;
  logic [31:0] inst2;

  int          n_chk = 0;
  int          n_err = 0;
  int          cyc   = 0;
  int          lat;
  logic [31:0] key;
  logic [31:0] pq_addr [$];
  logic [31:0] pq_key  [$];
  int          pq_due  [$];
  logic [4:0]  exp_req;

  always #5 clk = ~clk;

  if_fetch_stage u_dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_flag(branch_flag),
    .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .PC_if(PC_if), .inst_if(inst_if)
  );

  if_fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
    .clk(clk), .rst(rst), .stall(stall2), .branch_flag(branch2),
    .branch_target(target2), .imem_req(req2), .imem_addr(addr2),
    .imem_gnt(gnt2), .imem_rvalid(rvalid2), .imem_rdata(rdata2),
    .PC_if(pc2), .inst_if(inst2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Records this cycle's grant, advances one clock, then drives any due response.
  task automatic tick();
    if (imem_req && imem_gnt) begin
      pq_addr.push_back(imem_addr);
      pq_key.push_back(key);
      pq_due.push_back(cyc + lat);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (pq_due.size() != 0 && pq_due[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = pq_addr[0] ^ pq_key[0];
      void'(pq_addr.pop_front());
      void'(pq_key.pop_front());
      void'(pq_due.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
    #1;
  endtask

  initial begin
    rst = 1'b0; stall = '0; branch_flag = 1'b0; branch_target = '0;
    imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    stall2 = '0; branch2 = 1'b0; target2 = '0; gnt2 = 1'b1; rvalid2 = 1'b0; rdata2 = '0;
    lat = 1; key = 32'hA5A5_0000;
    @(posedge clk); #1;
    tick(); tick();

    chk("rst_req",  32'(imem_req), 32'h0);
    chk("rst_pc",   PC_if, 32'h0);
    chk("rst_inst", inst_if, 32'h0);
    chk("rst_pc_wrap", pc2, 32'hFFFF_FFF8);

    // Streaming with 1-cycle memory; wrap instance runs alongside with no responses.
    pq_addr.delete(); pq_key.delete(); pq_due.delete();
    rst = 1'b1; #1;
    chk("t1_addr_c0", imem_addr, 32'h0);
    chk("t1_pc_c0", PC_if, 32'h0);
    chk("t5_addr_c0", addr2, 32'hFFFF_FFF8);
    tick();
    chk("t1_addr_c1", imem_addr, 32'h4);
    chk("t1_inst_c1", inst_if, 32'h0);
    chk("t1_pc_c1", PC_if, 32'h0);
    chk("t5_addr_c1", addr2, 32'hFFFF_FFFC);
    tick();
    chk("t5_addr_c2", addr2, 32'h0);
    chk("t5_req_c2", 32'(req2), 32'h1);
    for (int k = 2; k < 8; k++) begin
      chk("t1_pc", PC_if, 32'((k - 2) * 4));
      chk("t1_inst", inst_if, 32'((k - 2) * 4) ^ 32'hA5A5_0000);
      chk("t1_addr", imem_addr, 32'(k * 4));
      if (k == 3) chk("t5_addr_c3", addr2, 32'h4);
      if (k == 4) chk("t5_req_c4", 32'(req2), 32'h0);
      tick();
    end

    // Stall for five cycles; prefetch fills to four entries and stops.
    stall = 6'b000010; #1;
    exp_req = 5'b00011;
    for (int k = 0; k < 5; k++) begin
      chk("t2_pc_hold", PC_if, 32'h18);
      chk("t2_inst_hold", inst_if, 32'hA5A5_0018);
      chk("t2_req", 32'(exp_req[k]), 32'(imem_req));
      tick();
    end
    stall = '0; #1;
    chk("t2_pc_c13", PC_if, 32'h18);
    chk("t2_req_c13", 32'(imem_req), 32'h0);
    tick();
    chk("t2_pc_c14", PC_if, 32'h1C);
    chk("t2_req_c14", 32'(imem_req), 32'h1);
    chk("t2_addr_c14", imem_addr, 32'h28);
    tick();
    chk("t2_pc_c15", PC_if, 32'h20);
    chk("t2_inst_c15", inst_if, 32'hA5A5_0020);
    chk("t2_addr_c15", imem_addr, 32'h2C);
    tick();
    chk("t2_pc_c16", PC_if, 32'h24);
    tick();
    chk("t2_pc_c17", PC_if, 32'h28);
    chk("t2_inst_c17", inst_if, 32'hA5A5_0028);

    // Redirect with two responses in flight.
    rst = 1'b0; tick(); tick();
    pq_addr.delete(); pq_key.delete(); pq_due.delete();
    lat = 3; rst = 1'b1; #1;
    tick(); tick();
    branch_flag = 1'b1; branch_target = 32'h0000_0103; #1;
    chk("t3_req_br", 32'(imem_req), 32'h0);
    chk("t3_inst_br", inst_if, 32'h0);
    tick();
    branch_flag = 1'b0; #1;
    chk("t3_addr_tgt", imem_addr, 32'h100);
    chk("t3_req_tgt", 32'(imem_req), 32'h1);
    chk("t3_pc_tgt", PC_if, 32'h100);
    for (int k = 3; k < 7; k++) begin
      chk("t3_inst_bubble", inst_if, 32'h0);
      tick();
    end
    chk("t3_pc_first", PC_if, 32'h100);
    chk("t3_inst_first", inst_if, 32'hA5A5_0100);
    tick();
    chk("t3_pc_second", PC_if, 32'h104);
    chk("t3_inst_second", inst_if, 32'hA5A5_0104);

    // Grant withheld three cycles, then 4-cycle response latency.
    rst = 1'b0; tick(); tick();
    pq_addr.delete(); pq_key.delete(); pq_due.delete();
    lat = 4; imem_gnt = 1'b0; rst = 1'b1; #1;
    for (int k = 0; k < 3; k++) begin
      chk("t4_addr_hold", imem_addr, 32'h0);
      chk("t4_req_hold", 32'(imem_req), 32'h1);
      tick();
    end
    imem_gnt = 1'b1; #1;
    for (int k = 3; k < 8; k++) begin
      chk("t4_inst_bubble", inst_if, 32'h0);
      tick();
    end
    chk("t4_pc_c8", PC_if, 32'h0);
    chk("t4_inst_c8", inst_if, 32'hA5A5_0000);
    chk("t4_req_full", 32'(imem_req), 32'h0);
    tick();
    chk("t4_pc_c9", PC_if, 32'h4);
    chk("t4_inst_c9", inst_if, 32'hA5A5_0004);
    chk("t4_addr_c9", imem_addr, 32'h10);
    tick();
    chk("t4_pc_c10", PC_if, 32'h8);
    tick();
    chk("t4_pc_c11", PC_if, 32'hC);
    chk("t4_inst_c11", inst_if, 32'hA5A5_000C);
    tick();
    chk("t4_pc_c12", PC_if, 32'h10);
    chk("t4_inst_c12", inst_if, 32'h0);

    // Reset with three requests outstanding; stale responses carry a different tag.
    rst = 1'b0; tick(); tick();
    pq_addr.delete(); pq_key.delete(); pq_due.delete();
    lat = 5; key = 32'hDEAD_0000; rst = 1'b1; #1;
    tick(); tick(); tick();
    rst = 1'b0; #1;
    chk("t6_req_rst", 32'(imem_req), 32'h0);
    chk("t6_pc_rst", PC_if, 32'h0);
    chk("t6_inst_rst", inst_if, 32'h0);
    tick();
    tick();
    rst = 1'b1; imem_gnt = 1'b0; key = 32'hA5A5_0000; lat = 1; #1;
    chk("t6_stale_rvalid", 32'(imem_rvalid), 32'h1);
    chk("t6_addr_restart", imem_addr, 32'h0);
    for (int k = 5; k < 8; k++) begin
      chk("t6_inst_stale", inst_if, 32'h0);
      tick();
    end
    imem_gnt = 1'b1; #1;
    chk("t6_inst_c8", inst_if, 32'h0);
    tick();
    chk("t6_inst_c9", inst_if, 32'h0);
    tick();
    chk("t6_pc_c10", PC_if, 32'h0);
    chk("t6_inst_c10", inst_if, 32'hA5A5_0000);
    tick();
    chk("t6_pc_c11", PC_if, 32'h4);
    chk("t6_inst_c11", inst_if, 32'hA5A5_0004);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
